gray_ptr_ctrl: RTL and testbench
================================

// Module: gray_ptr_ctrl
// PURPOSE
// - Write-side pointer controller for a dual-clock FIFO. It sequences a binary
//   pointer and its Gray-coded copy, and synchronizes the read-side Gray pointer.
// - Generates Full and Level flags and accepts push requests through a req/ack
//   handshake.
// - Sits between the FIFO write client and the storage RAM. Its GrayPtr output
//   feeds the read-domain synchronizer.
// PARAMETERS
// - ADDR_W       4  FIFO depth = 2**ADDR_W; pointers are ADDR_W+1 bits (extra wrap bit)
// - SYNC_STAGES  2  flop stages on RemoteGrayPtr (legal range 2..4)
// - AF_THRESH    12 AlmostFull threshold in entries (only used with GRAY_PTR_ALMOST_FULL_EN)
// PORTS
// - Clk            in   1         write-domain clock; all state rises on posedge
// - RstN           in   1         asynchronous active-low reset
// - IncReq         in   1         push request from client
// - IncAck         out  1         push accepted this cycle
// - RemoteGrayPtr  in   ADDR_W+1  read-side Gray pointer, asynchronous to Clk
// - Addr           out  ADDR_W    RAM write address = BinPtr[ADDR_W-1:0]
// - BinPtr         out  ADDR_W+1  binary write pointer
// - GrayPtr        out  ADDR_W+1  registered Gray write pointer, exported to the read domain
// - Full           out  1         registered full flag
// - Level          out  ADDR_W+1  occupancy as seen from the write domain, range 0..2**ADDR_W
// - AlmostFull     out  1         present only with GRAY_PTR_ALMOST_FULL_EN
// BEHAVIOUR
// - Reset: async on RstN=0, with no clock edge needed.
//   - BinPtr, GrayPtr, Full, Level, AlmostFull and all sync flops are 0.
//   - IncAck is 0 whenever RstN=0.
// - Handshake: IncAck = IncReq & ~Full (combinational). No ack while Full=1;
//   a rejected request must be held by the client.
// - Push: on a posedge with IncAck=1:
//   - BinPtr <= BinPtr+1, modulo 2**(ADDR_W+1), wrapping from all-ones to 0.
//   - GrayPtr <= bin2gray(BinPtr+1).
//   - Latency: 1 cycle from ack to the pointer update.
// - GrayPtr is driven only from a flop, never from combinational logic. Each
//   update changes exactly 1 bit, including at wrap (100..0 -> 000..0).
// - Sync: RemoteGrayPtr passes through SYNC_STAGES flops to give SyncGray.
//   SyncBin = gray2bin(SyncGray).
// - Full: registered every cycle as NextGray == {~SyncGray[ADDR_W:ADDR_W-1], SyncGray[ADDR_W-2:0]}.
//   - NextGray is the post-push Gray value, or GrayPtr when no push occurs.
//   - Full asserts on the same edge that the last slot is written.
//   - Full deasserts SYNC_STAGES+1 edges after RemoteGrayPtr advances.
// - Level = BinPtr - SyncBin, modulo 2**(ADDR_W+1), combinational from flops.
//   Level is pessimistic: it over-reports by the entries still in synchronizer flight.
// - Simultaneous push and remote advance: both are applied. Full is evaluated
//   against the SyncGray value sampled on that edge.
// - Reset mid-operation: all state drops to 0 immediately. The read side must be
//   reset in the same window; this is a system requirement and is not checked here.
// - Binary-to-Gray and Gray-to-binary conversion is pure XOR logic; no
//   arithmetic is done on Gray values.
// CONFIGURATION
// - GRAY_PTR_ALMOST_FULL_EN defined:
//   - Adds the AlmostFull output and a register for it.
//   - AlmostFull <= (NextLevel >= AF_THRESH), updated on the same edges as Full.
//   - Reset value 0.
// - Not defined: the AlmostFull port, its logic and the use of AF_THRESH are
//   absent. All other behaviour is identical.
// STRUCTURE
// - Package gray_ptr_pkg holds:
//   - Functions bin2gray(), gray2bin() and hamming1(a,b).
//   - ptr_t typedef, parameterized via a localparam width.
// - Sub-module gray_sync (SYNC_STAGES x width flop chain, async active-low reset).
//   It is instantiated once for RemoteGrayPtr and is reused by the read-side controller.
// TESTING
// - Benches run with ADDR_W=3 and SYNC_STAGES=2 unless noted.
// - Reset: RstN=0 with IncReq=1 -> BinPtr=0, GrayPtr=0, Full=0, Level=0, IncAck=0,
//   all without a clock edge.
// - Fill: RemoteGrayPtr=0, IncReq=1 for 10 cycles:
//   - Exactly 8 acks.
//   - GrayPtr steps 0,1,3,2,6,7,5,4,12.
//   - Full=1 on the edge of the 8th push.
//   - Level=8, and IncAck=0 for cycles 9-10.
// - Release: from Full, set RemoteGrayPtr=1 -> Full falls exactly 3 edges later,
//   Level=7, and the next push is acked with BinPtr=9.
// - Wrap: 40 pushes with RemoteGrayPtr tracking the write pointer with lag 2 ->
//   BinPtr wraps 15->0 and GrayPtr 8->0. hamming1 holds on every GrayPtr change;
//   Full is never set.
// - Mid-op reset: pulse RstN low mid-cycle at Level=5 -> all outputs are 0
//   before the next posedge. The first push after release gives GrayPtr=1.
// - GRAY_PTR_ALMOST_FULL_EN with AF_THRESH=6 -> AlmostFull rises on the 6th push
//   and falls when Level drops to 5.

Source files
------------

// File: rtl/gray_ptr_pkg.sv
// Shared pointer helpers for the dual-clock FIFO pointer controllers.
// Conversions operate on a wide container type; callers zero-extend their
// narrower pointers in and slice the result back to their own width.
package gray_ptr_pkg;

   localparam int PTR_MAX_W = 16;

   typedef logic [PTR_MAX_W-1:0] ptr_t;

   // Binary to reflected Gray: each bit XORed with its upper neighbour.
   function automatic ptr_t bin2gray(input ptr_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // Gray to binary: running XOR from the MSB downwards.
   function automatic ptr_t gray2bin(input ptr_t gray);
      ptr_t bin;
      bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

   // True when a and b differ in exactly one bit position.
   function automatic logic hamming1(input ptr_t a, input ptr_t b);
      return ($countones(a ^ b) == 1);
   endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into clk.
// Shared by the write-side and read-side pointer controllers.
module gray_sync #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [STAGES];

   // Shift the remote pointer through STAGES flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: this array is a flop chain, not a RAM, so every stage takes the reset value.
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments make each stage sample the pre-edge value of its predecessor.
         stage_q[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO: binary and Gray write
// pointers, synchronized read pointer, registered Full, pessimistic Level.
// Optional feature macro: GRAY_PTR_ALMOST_FULL_EN adds a registered AlmostFull
// output driven by the AF_THRESH parameter.
module gray_ptr_ctrl
   import gray_ptr_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter int SYNC_STAGES = 2
`ifdef GRAY_PTR_ALMOST_FULL_EN
   , parameter int AF_THRESH = 12
`endif
) (
   input  logic              Clk,
   input  logic              RstN,
   input  logic              IncReq,
   output logic              IncAck,
   input  logic [ADDR_W:0]   RemoteGrayPtr,
   output logic [ADDR_W-1:0] Addr,
   output logic [ADDR_W:0]   BinPtr,
   output logic [ADDR_W:0]   GrayPtr,
   output logic              Full,
`ifdef GRAY_PTR_ALMOST_FULL_EN
   output logic              AlmostFull,
`endif
   output logic [ADDR_W:0]   Level
);

   localparam int PTR_W = ADDR_W + 1;

   typedef logic [PTR_W-1:0] wptr_t;

   wptr_t bin_q;
   wptr_t gray_q;
   logic  full_q;

   wptr_t bin_next;
   wptr_t gray_next;
   wptr_t sync_gray;
   wptr_t sync_bin;
   wptr_t full_pattern;
   logic  inc_ack;
   logic  full_next;

   ptr_t  gray_next_wide;
   ptr_t  sync_bin_wide;
   logic  unused_hi;

   gray_sync #(
      .WIDTH  (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_remote_sync (
      .clk   (Clk),
      .rst_n (RstN),
      .d     (RemoteGrayPtr),
      .q     (sync_gray)
   );

   // Gating with RstN keeps the ack low while reset is held, even with Full=0.
   assign inc_ack = IncReq & ~full_q & RstN;

   // Post-push binary pointer; holds when no push is accepted.
   always_comb begin
      // NOTE: default assigned first so every path drives bin_next and no latch is inferred.
      bin_next = bin_q;
      if (inc_ack) begin
         bin_next = bin_q + PTR_W'(1);
      end
   end

   assign gray_next_wide = bin2gray(ptr_t'(bin_next));
   assign gray_next      = gray_next_wide[PTR_W-1:0];
   assign sync_bin_wide  = gray2bin(ptr_t'(sync_gray));
   assign sync_bin       = sync_bin_wide[PTR_W-1:0];

   // Upper bits of the wide conversions are always zero here.
   assign unused_hi = ^{gray_next_wide[PTR_MAX_W-1:PTR_W], sync_bin_wide[PTR_MAX_W-1:PTR_W]};

   // Full when our next Gray pointer equals the read pointer one lap ahead:
   // in Gray code that is the top two bits inverted, the rest equal.
   assign full_pattern = {~sync_gray[ADDR_W:ADDR_W-1], sync_gray[ADDR_W-2:0]};
   assign full_next    = (gray_next == full_pattern);

   // Pointer pair and Full flag registers.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         bin_q  <= '0;
         gray_q <= '0;
         full_q <= 1'b0;
      end else begin
         bin_q  <= bin_next;
         gray_q <= gray_next;
         full_q <= full_next;
      end
   end

`ifdef GRAY_PTR_ALMOST_FULL_EN
   wptr_t next_level;
   logic  af_q;

   assign next_level = bin_next - sync_bin;

   // AlmostFull register, evaluated on the same edges as Full.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         af_q <= 1'b0;
      end else begin
         af_q <= (int'(next_level) >= AF_THRESH);
      end
   end

   assign AlmostFull = af_q;
`else
   // No AlmostFull flag in this build.
`endif

   assign IncAck  = inc_ack;
   assign BinPtr  = bin_q;
   assign GrayPtr = gray_q;
   assign Addr    = bin_q[ADDR_W-1:0];
   assign Full    = full_q;
   assign Level   = bin_q - sync_bin;

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Self-checking bench for gray_ptr_ctrl (ADDR_W=3, SYNC_STAGES=2).
// Reference model tracks entry counts as integers and a queue for the
// synchronizer delay; Gray values are derived only for comparison.
module tb_gray_ptr_ctrl;

   localparam int ADDR_W      = 3;
   localparam int SYNC_STAGES = 2;
   localparam int PTR_W       = ADDR_W + 1;
   localparam int DEPTH       = 1 << ADDR_W;
   localparam int MOD         = 1 << PTR_W;
   localparam int AF_T        = 6;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              inc_req;
   logic              inc_ack;
   logic [PTR_W-1:0]  rd_bin;
   logic [PTR_W-1:0]  remote_gray;
   logic [ADDR_W-1:0] addr;
   logic [PTR_W-1:0]  bin_ptr;
   logic [PTR_W-1:0]  gray_ptr;
   logic              full;
   logic [PTR_W-1:0]  level;
`ifdef GRAY_PTR_ALMOST_FULL_EN
   logic              almost_full;
`endif

   // Read side publishes its pointer in Gray code.
   assign remote_gray = rd_bin ^ (rd_bin >> 1);

   gray_ptr_ctrl #(
      .ADDR_W      (ADDR_W),
      .SYNC_STAGES (SYNC_STAGES)
`ifdef GRAY_PTR_ALMOST_FULL_EN
      , .AF_THRESH (AF_T)
`endif
   ) dut (
      .Clk           (clk),
      .RstN          (rst_n),
      .IncReq        (inc_req),
      .IncAck        (inc_ack),
      .RemoteGrayPtr (remote_gray),
      .Addr          (addr),
      .BinPtr        (bin_ptr),
      .GrayPtr       (gray_ptr),
      .Full          (full),
`ifdef GRAY_PTR_ALMOST_FULL_EN
      .AlmostFull    (almost_full),
`endif
      .Level         (level)
   );

   always #5 clk = ~clk;

   int total;
   int bad;
   int obs_acks;

   // Reference model state.
   int m_wr;
   bit m_full;
   bit m_af;
   int m_pipe[$];

   function automatic int wrap(input int v);
      return ((v % MOD) + MOD) % MOD;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wr   = 0;
      m_full = 1'b0;
      m_af   = 1'b0;
      m_pipe = {};
      for (int i = 0; i < SYNC_STAGES; i++) m_pipe.push_back(0);
   endtask

   task automatic check_outputs();
      check("bin_ptr", bin_ptr, m_wr);
      check("gray_ptr", gray_ptr, m_wr ^ (m_wr >> 1));
      check("addr", addr, m_wr % DEPTH);
      check("full", full, m_full);
      check("level", level, wrap(m_wr - m_pipe[0]));
`ifdef GRAY_PTR_ALMOST_FULL_EN
      check("almost_full", almost_full, m_af);
`endif
   endtask

   // One clock: check the combinational ack, advance the model, check outputs.
   task automatic tick();
      logic exp_ack;
      int   seen;
      int   nxt;
      #1;
      exp_ack = inc_req && !m_full;
      check("inc_ack", inc_ack, exp_ack);
      if (inc_ack === 1'b1) obs_acks++;
      @(posedge clk);
      seen = m_pipe[0];
      nxt  = exp_ack ? wrap(m_wr + 1) : m_wr;
      m_full = (wrap(nxt - seen) == DEPTH);
      m_af   = (wrap(nxt - seen) >= AF_T);
      m_wr   = nxt;
      void'(m_pipe.pop_front());
      m_pipe.push_back(int'(rd_bin));
      #1;
      check_outputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_gray[10] = '{1, 3, 2, 6, 7, 5, 4, 12, 12, 12};
      int edges;
      logic [PTR_W-1:0] prev_bin;
      logic [PTR_W-1:0] prev_gray;
      bit saw_full;
      bit saw_bin_wrap;
      bit saw_gray_wrap;

      total    = 0;
      bad      = 0;
      obs_acks = 0;
      rst_n    = 1'b0;
      inc_req  = 1'b1;
      rd_bin   = '0;
      model_reset();

      // Reset with a pending request, before any clock edge.
      #2;
      check("rst_bin", bin_ptr, 0);
      check("rst_gray", gray_ptr, 0);
      check("rst_full", full, 0);
      check("rst_level", level, 0);
      check("rst_ack", inc_ack, 0);

      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Fill from empty with the read side parked at 0.
      obs_acks = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("fill_gray_seq", gray_ptr, exp_gray[i]);
      end
      check("fill_acks", obs_acks, 8);
      check("fill_level", level, 8);
      check("fill_full", full, 1);

      // Release one slot: Full must fall SYNC_STAGES+1 edges later.
      inc_req = 1'b0;
      rd_bin  = 4'd1;
      edges   = 0;
      while (full === 1'b1 && edges < 8) begin
         tick();
         edges++;
      end
      check("release_edges", edges, SYNC_STAGES + 1);
      check("release_level", level, 7);
      inc_req = 1'b1;
      tick();
      check("release_push_bin", bin_ptr, 9);

      // Drain to lag 2, then push 40 times with the reader trailing by 2.
      inc_req = 1'b0;
      rd_bin  = 4'(wrap(m_wr - 2));
      repeat (4) tick();
      saw_full      = 1'b0;
      saw_bin_wrap  = 1'b0;
      saw_gray_wrap = 1'b0;
      obs_acks      = 0;
      for (int i = 0; i < 40; i++) begin
         prev_bin  = bin_ptr;
         prev_gray = gray_ptr;
         rd_bin    = 4'(wrap(m_wr - 2));
         inc_req   = 1'b1;
         tick();
         if (gray_ptr !== prev_gray)
            check("gray_one_bit", $countones(gray_ptr ^ prev_gray), 1);
         if (prev_bin == 4'd15 && bin_ptr == 4'd0) saw_bin_wrap = 1'b1;
         if (prev_gray == 4'd8 && gray_ptr == 4'd0) saw_gray_wrap = 1'b1;
         if (full !== 1'b0) saw_full = 1'b1;
      end
      check("wrap_acks", obs_acks, 40);
      check("wrap_bin_seen", saw_bin_wrap, 1);
      check("wrap_gray_seen", saw_gray_wrap, 1);
      check("wrap_never_full", saw_full, 0);

      // Random pushes and read-side advances against the model.
      for (int i = 0; i < 150; i++) begin
         inc_req = 1'($urandom_range(0, 1));
         if (wrap(m_wr - int'(rd_bin)) > 0 && $urandom_range(0, 2) != 0)
            rd_bin = rd_bin + 4'd1;
         tick();
      end

      // Build Level=5 from empty, then reset mid-cycle.
      inc_req = 1'b0;
      rd_bin  = 4'(m_wr);
      repeat (4) tick();
      inc_req = 1'b1;
      repeat (5) tick();
      check("pre_reset_level", level, 5);
      #2;
      rst_n  = 1'b0;
      rd_bin = '0;
      #1;
      check("midrst_bin", bin_ptr, 0);
      check("midrst_gray", gray_ptr, 0);
      check("midrst_addr", addr, 0);
      check("midrst_full", full, 0);
      check("midrst_level", level, 0);
      check("midrst_ack", inc_ack, 0);
      #1;
      rst_n = 1'b1;
      model_reset();
      tick();
      check("post_reset_gray", gray_ptr, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
